dmem_responder: RTL and testbench

Data-memory responder, the slave end of the core's LSU data-memory interface (ram_we / ram_addr / ram_wdata).
- Accepts one load/store request at a time over a valid/ready request channel.
- Holds word-organised storage, applies byte strobes on stores, and returns read data or an error over a valid/ready response channel after a configurable latency.
- Sits between the LSU and the simulation memory, so the core can later be built multi-cycle.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lfsr16.sv | 28 ++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder slice.
//   state_t    : responder FSM states (IDLE / WAIT / RESP)
//   STRB_W     : number of byte lanes per 32-bit word
//   CNT_W      : width of the wait counter (holds up to 16)
//   LFSR_SEED  : reset value of the random-delay LFSR
//   LFSR_TAPS  : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          STRB_W    = 4;
    localparam int          CNT_W     = 5;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dmem_lfsr16.sv
// -----------------------------------------------------------------------------
// dmem_lfsr16
// 16-bit Fibonacci LFSR used to draw a per-transaction wait when the
// responder is built with MEM_RAND_DELAY_EN.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset (loads LFSR_SEED)
//   en    in   advance one step on this edge
//   state out  current 16-bit LFSR value
// -----------------------------------------------------------------------------
module dmem_lfsr16
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Slave end of the LSU data-memory interface. Accepts one load/store at a
// time, waits a configurable number of cycles, performs the word access with
// byte strobes, and holds the response until the requester takes it.
//
// Build option: define MEM_RAND_DELAY_EN to replace the fixed LATENCY with a
// per-transaction wait drawn from a 16-bit LFSR (low 4 bits, 0..15).
//
// Parameters:
//   ADDR_BASE    byte address of word 0
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   LATENCY      extra wait cycles between acceptance and access (0..15)
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  responder idle and able to accept
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address, bits [1:0] ignored
//   req_wdata   in   lane-aligned store data
//   req_wstrb   in   byte-lane write enables
//   resp_valid  out  response present
//   resp_ready  in   requester accepts response
//   resp_rdata  out  load data; 0 for stores and errors
//   resp_err    out  address out of range
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int          AW     = $clog2(DEPTH_WORDS);
    // Range bounds in 33 bits so a window touching 2^32 cannot wrap.
    localparam logic [32:0] BASE_X = {1'b0, ADDR_BASE};
    localparam logic [32:0] TOP_X  = BASE_X + (33'(DEPTH_WORDS) << 2);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               cap_we;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [STRB_W-1:0]  cap_wstrb;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic               do_access;
    logic               in_range;
    logic [31:0]        offset;
    logic [AW-1:0]      word_idx;
    logic [3:0]         wait_cycles;
    logic               unused_offset;

    assign req_ready  = rst && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    // The access happens on the edge that leaves WAIT for RESP.
    assign do_access  = (state == WAIT) && (cnt == CNT_W'(1));

    assign in_range      = ({1'b0, cap_addr} >= BASE_X) && ({1'b0, cap_addr} < TOP_X);
    assign offset        = cap_addr - ADDR_BASE;
    assign word_idx      = offset[AW+1:2];
    assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

`ifdef MEM_RAND_DELAY_EN
    logic [15:0] lfsr_state;
    logic        unused_lfsr;

    // Sampled on the accept edge; the LFSR steps on that same edge.
    dmem_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .state (lfsr_state)
    );

    assign wait_cycles = lfsr_state[3:0];
    assign unused_lfsr = ^lfsr_state[15:4];
`else
    assign wait_cycles = 4'(LATENCY);
`endif

    // Control FSM and response registers. The counter holds the number of
    // edges left until RESP, the access edge included, so acceptance at edge N
    // gives resp_valid after edge N+1+wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_wstrb <= req_wstrb;
                        cnt       <= {1'b0, wait_cycles} + CNT_W'(1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (do_access) begin
                        resp_err   <= !in_range;
                        resp_rdata <= (!cap_we && in_range) ? mem[word_idx] : '0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage: not reset; byte lanes committed only on an in-range store.
    always_ff @(posedge clk) begin
        if (do_access && cap_we && in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (cap_wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders with LATENCY 1, 3 and 5. Stimulus pushes the expected
// response into a shared queue; a monitor pops and compares on every response
// handshake. Inputs change 1 time unit after the rising edge; the monitor
// samples on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int NI = 3;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic [3:0]  req_wstrb  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .ADDR_BASE   (32'h8000_0000),
            .DEPTH_WORDS (1024),
            .LATENCY     ((g == 0) ? 1 : ((g == 1) ? 3 : 5))
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_wstrb  (req_wstrb[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 5);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic [31:0] rdata, input logic err);
        exp_t t;
        t.idx   = i;
        t.rdata = rdata;
        t.err   = err;
        exp_q.push_back(t);
    endtask

    // Present a request and return just after the accepting edge.
    task automatic issue(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        int n = 0;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wstrb[i] = strb;
        req_valid[i] = 1'b1;
        while (!req_ready[i] && n < 40) begin
            step();
            n++;
        end
        chk("req_ready_for_accept", 32'(req_ready[i]), 32'd1);
        step();
        req_valid[i] = 1'b0;
    endtask

    // Count edges after acceptance until resp_valid rises.
    task automatic wait_resp(input int i);
        int c = 0;
        while (!resp_valid[i] && c < 40) begin
            step();
            c++;
        end
        chk($sformatf("latency_inst%0d", i), 32'(c), 32'(lat_of(i) + 1));
    endtask

    task automatic txn(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rdata, input logic exp_err);
        push_exp(i, exp_rdata, exp_err);
        issue(i, we, addr, wdata, strb);
        wait_resp(i);
        step();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i] && resp_valid[i] && resp_ready[i]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp inst%0d: got rdata %h err %b, required no response",
                             i, resp_rdata[i], resp_err[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_inst", 32'(i), 32'(mon_e.idx));
                    chk($sformatf("resp_rdata_inst%0d", i), resp_rdata[i], mon_e.rdata);
                    chk($sformatf("resp_err_inst%0d", i), 32'(resp_err[i]), 32'(mon_e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i]        = 1'b0;
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = '0;
            req_wdata[i]  = '0;
            req_wstrb[i]  = '0;
            resp_ready[i] = 1'b1;
        end
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            chk("reset_req_ready",  32'(req_ready[i]),  32'd0);
            chk("reset_resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("reset_resp_rdata", resp_rdata[i],       32'd0);
            chk("reset_resp_err",   32'(resp_err[i]),   32'd0);
        end
        for (int i = 0; i < NI; i++) rst[i] = 1'b1;
        step();

        // LATENCY=1: full store then load
        txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        // Byte strobes
        txn(0, 1'b1, 32'h8000_0014, 32'h1122_3344, 4'hF,    32'h0, 1'b0);
        txn(0, 1'b1, 32'h8000_0014, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h8000_0014, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0);
        // Range: just past the top, top word, just below the base, base word
        txn(0, 1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0, 1'b1);
        txn(0, 1'b1, 32'h8000_0FFC, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
        txn(0, 1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
        txn(0, 1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h55AA_55AA, 1'b0);
        txn(0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0);

        // Backpressure: hold resp_ready low for 5 cycles in RESP
        resp_ready[0] = 1'b0;
        push_exp(0, 32'hDEAD_BEEF, 1'b0);
        issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        wait_resp(0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
            chk("bp_resp_rdata", resp_rdata[0],       32'hDEAD_BEEF);
            chk("bp_req_ready",  32'(req_ready[0]),  32'd0);
            step();
        end
        resp_ready[0] = 1'b1;
        step();
        chk("bp_release_req_ready",  32'(req_ready[0]),  32'd1);
        chk("bp_release_resp_valid", 32'(resp_valid[0]), 32'd0);

        // LATENCY=3: store, zero-strobe store, readback
        txn(1, 1'b1, 32'h8000_0040, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
        txn(1, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
        txn(1, 1'b0, 32'h8000_0040, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0);

        // LATENCY=5: reset while the store is still waiting
        txn(2, 1'b1, 32'h8000_0020, 32'h0, 4'hF, 32'h0, 1'b0);
        issue(2, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF);
        step();
        step();
        rst[2] = 1'b0;
        #1;
        chk("midwait_rst_resp_valid", 32'(resp_valid[2]), 32'd0);
        chk("midwait_rst_req_ready",  32'(req_ready[2]),  32'd0);
        step();
        step();
        rst[2] = 1'b1;
        #1;
        chk("after_rst_req_ready",  32'(req_ready[2]),  32'd1);
        chk("after_rst_resp_valid", 32'(resp_valid[2]), 32'd0);
        repeat (8) step();
        txn(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h0, 1'b0);

        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
